// File: rtl/hamming_secded_pipe_pkg.sv
// Shared types and helpers for the pipelined Hamming SECDED unit.
package hamming_secded_pipe_pkg;

    typedef enum logic {
        kENC = 1'b0,
        kDEC = 1'b1
    } op_mode_t;

    // Smallest Hamming parity count p with 2**p >= data_w + p + 1.
    function automatic int calc_par_w(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming syndrome and overall parity of one codeword.
module hamming_syndrome
    import hamming_secded_pipe_pkg::*;
#(
    parameter int CW_W  = 16,
    parameter int PAR_W = 4
) (
    input  logic [CW_W-1:0]  word,
    output logic [PAR_W-1:0] s,
    output logic             q
);

    // s is the XOR of the positions of all set bits; q is the XOR of every bit.
    always_comb begin
        s = '0;
        q = 1'b0;
        for (int i = 0; i < CW_W; i++) begin
            q = q ^ word[i];
            if (word[i]) s = s ^ PAR_W'(i);
        end
    end

endmodule

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready flow
// control and saturating single/double error counters.
module hamming_secded_pipe
    import hamming_secded_pipe_pkg::*;
#(
    parameter int  DATA_W = 11,
    parameter int  PAR_W  = 4,
    parameter int  CNT_W  = 8,
    localparam int CW_W   = DATA_W + PAR_W + 1
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  op_mode_t          in_mode,
    input  logic [CW_W-1:0]   in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output op_mode_t          out_mode,
    output logic [CW_W-1:0]   out_word,
    output logic [PAR_W-1:0]  out_syndrome,
    output logic              out_sec,
    output logic              out_ded,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    if (PAR_W < calc_par_w(DATA_W)) begin : g_par_check
        $error("PAR_W too small for DATA_W");
    end

    // Scatter data bits into the non-power-of-two positions, LSB first.
    function automatic logic [CW_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0] w;
        int k;
        w = '0;
        k = 0;
        for (int i = 1; i < CW_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (k < DATA_W) w[i] = d[k];
                k++;
            end
        end
        return w;
    endfunction

    // Gather data bits back from the non-power-of-two positions.
    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] w);
        logic [DATA_W-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int i = 1; i < CW_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (k < DATA_W) d[k] = w[i];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    logic             vld_p1;
    op_mode_t         mode_p1;
    logic [CW_W-1:0]  word_p1;
    logic             vld_p2;
    op_mode_t         mode_p2;
    logic [CW_W-1:0]  word_p2;
    logic [PAR_W-1:0] syn_p2;
    logic             sec_p2;
    logic             ded_p2;

    logic             load_p2;
    logic             hs_out;
    logic [CW_W-1:0]  syn_in;
    logic [PAR_W-1:0] syn;
    logic             par;
    logic [CW_W-1:0]  flip;
    logic [CW_W-1:0]  cw;
    logic [CW_W-1:0]  res_word;
    logic [PAR_W-1:0] res_syn;
    logic             res_sec;
    logic             res_ded;

    assign load_p2  = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !vld_p1 || load_p2;
    assign hs_out   = vld_p2 && out_ready;

    // ---- stage S1: capture the offered word and mode ----
    // S1 valid flag: refilled whenever the stage is free or draining.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) vld_p1 <= 1'b0;
        else if (in_ready) vld_p1 <= in_valid;
    end

    // S1 payload only moves on an accepted transaction.
    always_ff @(posedge CLK) begin
        if (in_valid && in_ready) begin
            mode_p1 <= in_mode;
            word_p1 <= in_word;
        end
    end

    // Encode reuses the syndrome logic: data with zero parity bits yields the parity.
    assign syn_in = (mode_p1 == kENC) ? place_data(word_p1[DATA_W-1:0]) : word_p1;

    hamming_syndrome #(
        .CW_W  (CW_W),
        .PAR_W (PAR_W)
    ) u_syndrome (
        .word (syn_in),
        .s    (syn),
        .q    (par)
    );

    // Build the codeword for encode, or classify and correct for decode.
    always_comb begin
        flip     = '0;
        cw       = '0;
        res_word = '0;
        res_syn  = '0;
        res_sec  = 1'b0;
        res_ded  = 1'b0;
        for (int i = 0; i < CW_W; i++) flip[i] = (int'(syn) == i);
        if (mode_p1 == kENC) begin
            cw = syn_in;
            for (int k = 0; k < PAR_W; k++) begin
                if ((1 << k) < CW_W) cw[1 << k] = syn[k];
            end
            cw[0]    = par ^ (^syn);
            res_word = cw;
        end else begin
            // A syndrome pointing outside the word is never a correctable error.
            if (par && (|flip)) begin
                res_sec = 1'b1;
                cw      = word_p1 ^ flip;
            end else begin
                res_ded = par || (syn != '0);
                cw      = word_p1;
            end
            res_word = CW_W'(extract_data(cw));
            res_syn  = syn;
        end
    end

    // ---- stage S2: result registers drive the outputs directly ----
    // S2 loads from S1 when empty or being consumed, otherwise holds steady.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p2  <= 1'b0;
            mode_p2 <= kENC;
            word_p2 <= '0;
            syn_p2  <= '0;
            sec_p2  <= 1'b0;
            ded_p2  <= 1'b0;
        end else if (load_p2) begin
            vld_p2  <= 1'b1;
            mode_p2 <= mode_p1;
            word_p2 <= res_word;
            syn_p2  <= res_syn;
            sec_p2  <= res_sec;
            ded_p2  <= res_ded;
        end else if (out_ready) begin
            vld_p2  <= 1'b0;
        end
    end

    // Error counters count consumed results; clear wins over a same-cycle increment.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else if (cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else begin
            if (hs_out && sec_p2) sec_cnt <= sat_inc(sec_cnt);
            if (hs_out && ded_p2) ded_cnt <= sat_inc(ded_cnt);
        end
    end

    assign out_valid    = vld_p2;
    assign out_mode     = mode_p2;
    assign out_word     = word_p2;
    assign out_syndrome = syn_p2;
    assign out_sec      = sec_p2;
    assign out_ded      = ded_p2;

endmodule

// File: tb/tb_hamming_secded_pipe.sv
// Scoreboard bench for hamming_secded_pipe (DATA_W=11, PAR_W=4, CNT_W=8).
module tb_hamming_secded_pipe;
    import hamming_secded_pipe_pkg::*;

    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct {
        op_mode_t    mode;
        logic [15:0] word;
        logic [3:0]  syn;
        logic        sec;
        logic        ded;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        Reset_n;
    logic        in_valid;
    logic        in_ready;
    op_mode_t    in_mode;
    logic [15:0] in_word;
    logic        out_valid;
    logic        out_ready;
    op_mode_t    out_mode;
    logic [15:0] out_word;
    logic [3:0]  out_syndrome;
    logic        out_sec;
    logic        out_ded;
    logic        cnt_clr;
    logic [7:0]  sec_cnt;
    logic [7:0]  ded_cnt;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc_cnt  = 0;
    bit   lat_chk  = 1'b1;
    bit   rdone;

    hamming_secded_pipe #(
        .DATA_W (11),
        .PAR_W  (4),
        .CNT_W  (8)
    ) dut (
        .CLK          (CLK),
        .Reset_n      (Reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_word      (in_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_word     (out_word),
        .out_syndrome (out_syndrome),
        .out_sec      (out_sec),
        .out_ded      (out_ded),
        .cnt_clr      (cnt_clr),
        .sec_cnt      (sec_cnt),
        .ded_cnt      (ded_cnt)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference encoder: parity computed position by position over the codeword.
    function automatic logic [15:0] m_enc(input logic [10:0] d);
        logic [15:0] w;
        logic b;
        w = '0;
        for (int j = 0; j < 11; j++) w[DPOS[j]] = d[j];
        for (int p = 1; p < 16; p = p * 2) begin
            b = 1'b0;
            for (int i = 1; i < 16; i++) if (((i & p) != 0) && (i != p)) b = b ^ w[i];
            w[p] = b;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] m_ext(input logic [15:0] w);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = w[DPOS[j]];
        return d;
    endfunction

    // Reference decoder: search for a single flip that gives a valid codeword.
    function automatic void m_dec(input logic [15:0] w, output logic [15:0] ew,
                                  output logic [3:0] es, output logic esec, output logic eded);
        logic [15:0] t;
        bit found;
        ew = {5'b0, m_ext(w)};
        es = '0;
        esec = 1'b0;
        eded = 1'b0;
        found = 1'b0;
        if (m_enc(m_ext(w)) != w) begin
            for (int b = 0; b < 16; b++) begin
                t = w ^ (16'd1 << b);
                if (!found && (m_enc(m_ext(t)) == t)) begin
                    found = 1'b1;
                    esec = 1'b1;
                    es = 4'(b);
                    ew = {5'b0, m_ext(t)};
                end
            end
            if (!found) begin
                eded = 1'b1;
                for (int i = 1; i < 16; i++) if (w[i]) es = es ^ 4'(i);
            end
        end
    endfunction

    // Offer one transaction, hold it until accepted, record the expectation.
    task automatic drive(input op_mode_t m, input logic [15:0] w, input logic [15:0] ew,
                         input logic [3:0] es, input logic esec, input logic eded);
        exp_t e;
        bit done;
        int guard;
        in_valid = 1'b1;
        in_mode  = m;
        in_word  = w;
        done  = 1'b0;
        guard = 0;
        while (!done) begin
            @(negedge CLK);
            if (in_ready) begin
                e.mode = m; e.word = ew; e.syn = es; e.sec = esec; e.ded = eded;
                e.acc_cyc = cyc; e.chk_lat = lat_chk;
                sb.push_back(e);
                acc_cnt++;
                done = 1'b1;
            end
            @(posedge CLK); #1;
            guard++;
            if (!done && guard > 200) begin
                chk("accept_timeout", 0, 1);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input op_mode_t m, input int nerr);
        logic [10:0] d;
        logic [15:0] w, ew;
        logic [3:0]  es;
        logic        esec, eded;
        int          b1, b2;
        d = 11'($urandom);
        if (m == kENC) begin
            drive(kENC, {5'($urandom), d}, m_enc(d), 4'd0, 1'b0, 1'b0);
        end else begin
            w  = m_enc(d);
            b1 = $urandom_range(0, 15);
            b2 = (b1 + $urandom_range(1, 15)) % 16;
            if (nerr >= 1) w[b1] = ~w[b1];
            if (nerr >= 2) w[b2] = ~w[b2];
            m_dec(w, ew, es, esec, eded);
            drive(kDEC, w, ew, es, esec, eded);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(posedge CLK); #1;
            g++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        @(posedge CLK); #1;
        cnt_clr = 1'b0;
        chk("clr_sec", sec_cnt, 0);
        chk("clr_ded", ded_cnt, 0);
    endtask

    // Output monitor: pops on every handshake, and checks hold during stalls.
    initial begin : monitor
        exp_t e;
        bit stalled;
        logic [15:0] held;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge CLK);
            if (stalled && Reset_n) chk("stall_hold", {15'b0, out_valid, out_word}, {15'b0, 1'b1, held});
            stalled = out_valid && !out_ready && Reset_n;
            held = out_word;
            if (out_valid && out_ready) begin
                chk("sec_ded_excl", out_sec & out_ded, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("mode", out_mode, e.mode);
                    chk("word", out_word, e.word);
                    chk("syndrome", out_syndrome, e.syn);
                    chk("sec", out_sec, e.sec);
                    chk("ded", out_ded, e.ded);
                    if (e.chk_lat) chk("latency", cyc - e.acc_cyc, 2);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : main
        int g;
        int base;
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_mode   = kENC;
        in_word   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        repeat (3) @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        @(negedge CLK);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_word", out_word, 0);
        chk("rst_sec_cnt", sec_cnt, 0);
        chk("rst_ded_cnt", ded_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge CLK); #1;

        // Encode constants, including ignored upper input bits.
        drive(kENC, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0);
        drive(kENC, 16'h0001, 16'h000F, 4'd0, 1'b0, 1'b0);
        drive(kENC, 16'h07FF, 16'hFFFF, 4'd0, 1'b0, 1'b0);
        drive(kENC, 16'hF801, 16'h000F, 4'd0, 1'b0, 1'b0);
        // Decode: single errors, double error, clean word.
        drive(kDEC, 16'h002F, 16'h0001, 4'd5, 1'b1, 1'b0);
        drive(kDEC, 16'h000E, 16'h0001, 4'd0, 1'b1, 1'b0);
        drive(kDEC, 16'h006F, 16'h0007, 4'd3, 1'b0, 1'b1);
        drive(kDEC, 16'hFFFF, 16'h07FF, 4'd0, 1'b0, 1'b0);
        wait_drain();
        chk("cnt_sec_after_dec", sec_cnt, 2);
        chk("cnt_ded_after_dec", ded_cnt, 1);
        pulse_clr();

        // Backpressure: 4 words offered while the output is blocked.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                drive(kENC, 16'h0123, m_enc(11'h123), 4'd0, 1'b0, 1'b0);
                drive(kENC, 16'h0456, m_enc(11'h456), 4'd0, 1'b0, 1'b0);
                drive(kENC, 16'h0789, m_enc(11'h789), 4'd0, 1'b0, 1'b0);
                drive(kENC, 16'h0ABC, m_enc(11'hABC), 4'd0, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(negedge CLK);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_accepts", acc_cnt - base, 2);
                @(posedge CLK); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Mixed traffic under random output stalls.
        rdone = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    if ($urandom_range(0, 1) == 0) send_rand(kENC, 0);
                    else send_rand(kDEC, $urandom_range(0, 2));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge CLK); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        pulse_clr();

        // Counter saturation with 300 single-error decodes.
        lat_chk = 1'b1;
        for (int n = 0; n < 300; n++) send_rand(kDEC, 1);
        wait_drain();
        chk("sec_saturate", sec_cnt, 255);
        chk("ded_after_sat", ded_cnt, 0);

        // Clear coinciding with a sec handshake.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        send_rand(kDEC, 1);
        g = 0;
        while (!out_valid && g < 10) begin
            @(posedge CLK); #1;
            g++;
        end
        chk("prio_wait_valid", out_valid, 1);
        out_ready = 1'b1;
        cnt_clr = 1'b1;
        @(posedge CLK); #1;
        cnt_clr = 1'b0;
        chk("clr_priority", sec_cnt, 0);
        wait_drain();

        // Reset with both stages full.
        lat_chk = 1'b1;
        send_rand(kDEC, 1);
        wait_drain();
        chk("sec_before_rst", sec_cnt, 1);
        lat_chk = 1'b0;
        out_ready = 1'b0;
        send_rand(kENC, 0);
        send_rand(kENC, 0);
        chk("full_before_rst", {in_ready, out_valid}, 2'b01);
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_out_word", out_word, 0);
        chk("rst_mid_sec", out_sec, 0);
        chk("rst_mid_sec_cnt", sec_cnt, 0);
        chk("rst_mid_ded_cnt", ded_cnt, 0);
        sb.delete();
        repeat (2) @(posedge CLK);
        #1;
        Reset_n = 1'b1;
        @(negedge CLK);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        @(posedge CLK); #1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        drive(kENC, 16'h0001, 16'h000F, 4'd0, 1'b0, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
